// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1010;
  localparam int         DEF_CNT_W   = 8;

  typedef enum logic {
    DET_NON_OVERLAP = 1'b0,
    DET_OVERLAP     = 1'b1
  } det_mode_e;

  // fill must hold values up to pat_w-1; never narrower than one bit
  function automatic int fill_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload.
// Define SEQ_DET_MATCH_CNT_EN to build in the saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  det_mode_e         mode;

  // window is the candidate match: stored history plus the bit arriving now
  assign window = {hist, x};
  assign mode   = overlap_en ? DET_OVERLAP : DET_NON_OVERLAP;
  assign z      = x_valid & ~pat_load & (fill == FILL_FULL) & (window == pat_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      z_q   <= 1'b0;
    end else begin
      z_q <= z;
      if (pat_load) begin
        pat_r <= pat_in;
        hist  <= '0;
        fill  <= '0;
      end else if (x_valid) begin
        if (z && (mode == DET_NON_OVERLAP)) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[PAT_W-2:0];
          if (fill != FILL_FULL) begin
            fill <= fill + 1'b1;
          end
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (z),
    .cnt (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector tables plus
// randomized traffic against a queue-based reference model.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             x_valid, x, overlap_en, pat_load, cnt_clr;
  logic [PAT_W-1:0] pat_in;
  logic             z, z_q;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: consumed bits since last restart, oldest first
  bit         mq[$];
  logic [3:0] mpat;
  int         mcnt;
  bit         mzq;
  bit         seenZ;

  typedef struct {
    bit v;
    bit xb;
    bit ov;
    bit expZ;
  } vec_t;

  seq_detector_param #(
    .PAT_W   (PAT_W),
    .PATTERN (4'b1010),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x_valid    (x_valid),
    .x          (x),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .cnt_clr    (cnt_clr),
    .z          (z),
    .z_q        (z_q),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelZ(input bit v, input bit xb, input bit ld);
    int val;
    if (!v || ld || (mq.size() != PAT_W - 1)) return 1'b0;
    val = 0;
    foreach (mq[i]) val = val * 2 + int'(mq[i]);
    val = val * 2 + int'(xb);
    return val == int'(mpat);
  endfunction

  task automatic modelReset();
    mq.delete();
    mpat = 4'b1010;
    mcnt = 0;
    mzq  = 1'b0;
  endtask

  // one clock cycle: drive, check z, clock, check registered outputs
  task automatic applyStimulus(input bit v, input bit xb, input bit ov, input bit ld,
                               input logic [3:0] pin, input bit clr);
    bit ez;
    @(negedge clk);
    x_valid = v; x = xb; overlap_en = ov; pat_load = ld; pat_in = pin; cnt_clr = clr;
    #1;
    ez = modelZ(v, xb, ld);
    seenZ = z;
    checkOutput("z", {31'b0, z}, {31'b0, ez});
    @(posedge clk);
    if (ld) begin
      mpat = pin;
      mq.delete();
    end else if (v) begin
      if (ez && !ov) mq.delete();
      else begin
        mq.push_back(xb);
        if (mq.size() > PAT_W - 1) void'(mq.pop_front());
      end
    end
    if (CNT_EN) begin
      if (clr) mcnt = 0;
      else if (ez && mcnt < CNT_MAX) mcnt++;
    end
    mzq = ez;
    #1;
    checkOutput("z_q", {31'b0, z_q}, {31'b0, mzq});
    checkOutput("match_cnt", 32'(match_cnt), 32'(mcnt));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    x_valid = 1'b1; x = 1'b1; overlap_en = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    #2;
    checkOutput("rst_z", {31'b0, z}, 32'd0);
    checkOutput("rst_z_q", {31'b0, z_q}, 32'd0);
    checkOutput("rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    x_valid = 1'b0;
    modelReset();
  endtask

  task automatic runTable(input string name, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].xb, tbl[i].ov, 1'b0, 4'b0, 1'b0);
      checkOutput(name, {31'b0, seenZ}, {31'b0, tbl[i].expZ});
    end
  endtask

  initial begin
    vec_t nonOvl[$];
    vec_t ovl[$];
    vec_t gaps[$];
    int gapZ;

    rst = 1'b1;
    x_valid = 1'b0; x = 1'b0; overlap_en = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    modelReset();

    nonOvl = '{'{1,1,0,0}, '{1,0,0,0}, '{1,1,0,0}, '{1,0,0,1}, '{1,1,0,0}, '{1,0,0,0}};
    ovl    = '{'{1,1,1,0}, '{1,0,1,0}, '{1,1,1,0}, '{1,0,1,1}, '{1,1,1,0}, '{1,0,1,1}};
    for (int i = 0; i < 4; i++) begin
      gaps.push_back('{1'b1, (i % 2 == 0), 1'b0, (i == 3)});
      for (int g = 0; g < 3; g++) gaps.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
    end

    #3;
    checkOutput("init_z_q", {31'b0, z_q}, 32'd0);
    checkOutput("init_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] non-overlapping 101010");
    runTable("nonovl_z", nonOvl);
    checkOutput("nonovl_cnt", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);

    doReset();
    $display("[TB] overlapping 101010");
    runTable("ovl_z", ovl);
    checkOutput("ovl_cnt", 32'(match_cnt), CNT_EN ? 32'd2 : 32'd0);

    doReset();
    $display("[TB] valid gaps");
    runTable("gap_z", gaps);

    doReset();
    $display("[TB] pattern reload");
    gapZ = 0;
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    applyStimulus(1, 0, 0, 0, 4'b0, 0);
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    applyStimulus(1, 0, 0, 1, 4'b0110, 0);
    gapZ += int'(seenZ);
    applyStimulus(1, 0, 0, 0, 4'b0, 0);
    gapZ += int'(seenZ);
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    gapZ += int'(seenZ);
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    gapZ += int'(seenZ);
    checkOutput("reload_early_z", 32'(gapZ), 32'd0);
    applyStimulus(1, 0, 0, 0, 4'b0, 0);
    checkOutput("reload_match_z", {31'b0, seenZ}, 32'd1);

    $display("[TB] reset mid-pattern");
    doReset();
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    applyStimulus(1, 0, 0, 0, 4'b0, 0);
    applyStimulus(1, 1, 0, 0, 4'b0, 0);
    doReset();
    applyStimulus(1, 0, 0, 0, 4'b0, 0);
    checkOutput("midrst_z", {31'b0, seenZ}, 32'd0);
    checkOutput("midrst_cnt", 32'(match_cnt), 32'd0);

    $display("[TB] counter saturation and clear");
    doReset();
    applyStimulus(0, 0, 1, 1, 4'b1111, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 0, 4'b0, 0);
    checkOutput("sat_cnt", 32'(match_cnt), CNT_EN ? 32'd3 : 32'd0);
    applyStimulus(1, 1, 1, 0, 4'b0, 1);
    checkOutput("clr_match_z", {31'b0, seenZ}, 32'd1);
    checkOutput("clr_cnt", 32'(match_cnt), 32'd0);

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                    ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b1010,
                    $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector: next generation of the fixed 1010 detector. Pattern width and reset pattern are parameters; the pattern can be reloaded at run time; overlapping and non-overlapping detection is selectable per cycle; an optional saturating match counter can be compiled in. The block sits on a 1-bit serial input stream with a valid qualifier. It flags matches to downstream control logic.

## Interface
- `PAT_W`, 4, pattern length in bits; legal range ≥ 2.
- `PATTERN`, 4'b1010, pattern loaded at reset; PAT_W bits wide.
- `CNT_W`, 8, match-counter width; legal range ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x_valid`  in  1  when high, `x` is a stream bit consumed this cycle.
- `x`  in  1  serial data bit; patterns arrive MSB first.
- `overlap_en`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `pat_load`  in  1  loads `pat_in` as the new pattern.
- `pat_in`  in  PAT_W  new pattern value.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `z`  out  1  Mealy match flag; combinational.
- `z_q`  out  1  `z` registered; one cycle later.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- State:
  - `pat_r` [PAT_W-1:0]: pattern register.
  - `hist` [PAT_W-2:0]: last valid bits, newest in bit 0.
  - `fill` [$clog2(PAT_W)-1:0]: number of valid history bits, saturating at PAT_W-1.
- Match condition: `z = x_valid & !pat_load & (fill == PAT_W-1) & ({hist, x} == pat_r)`.
- On a consumed bit (`x_valid & !pat_load`):
  - If `z` is high and `overlap_en` = 0: `fill` ← 0 and `hist` ← 0. The matched bits are not reused.
  - Otherwise: `hist` ← {hist[PAT_W-3:0], x} and `fill` ← min(fill+1, PAT_W-1). For PAT_W = 2, `hist` ← x.
- When `x_valid` = 0: `hist` and `fill` hold, and `z` = 0. Gaps in the stream are transparent.
- `pat_load` has priority over `x_valid`:
  - `pat_r` ← `pat_in`; `hist` and `fill` clear.
  - `x` in that cycle is discarded; `z` = 0.
- `overlap_en` is evaluated only in a match cycle. Changing it mid-stream affects the next match only.
- Counter update priority:
  1. `cnt_clr` clears the counter; a match in the same cycle is not counted.
  2. Otherwise `z` increments the counter.
  3. The counter saturates at 2^CNT_W − 1 and holds there.

## Timing
- Reset values (asynchronous, while `rst` = 1):
  - `pat_r` = PATTERN
  - `hist` = 0, `fill` = 0
  - `z_q` = 0, `match_cnt` = 0
  - `z` = 0, because `fill` = 0
- `z` latency: 0 cycles. It is asserted in the same cycle as the final pattern bit.
- `z_q` and `match_cnt` update on the rising edge that ends the match cycle.
- Earliest first match: the PAT_W-th consumed bit after reset or `pat_load`.
- Non-overlap: the next match requires PAT_W further consumed bits after a match.
- Overlap: the next match can occur on the following bit, e.g. pattern 1111 matching on a run of 1s.
- Reset asserted mid-pattern: the partial history is lost, with no spurious `z` after release.

## Configuration
- `SEQ_DET_MATCH_CNT_EN` defined: the counter and `cnt_clr` logic are present, as described above.
- `SEQ_DET_MATCH_CNT_EN` undefined: `match_cnt` is tied to 0, `cnt_clr` is ignored, and no counter flops exist. `z` and `z_q` are unaffected.

## Structure
- Package `seq_det_pkg`:
  - default `PAT_W`, `PATTERN` and `CNT_W` constants
  - `function` computing the `fill` width
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `cnt`):
  - instantiated only under `SEQ_DET_MATCH_CNT_EN`
  - reusable elsewhere

## Test plan
- **Non-overlap:** defaults, overlap_en = 0, stream 1,0,1,0,1,0 all valid → `z` high on bit 4 only; `match_cnt` = 1.
- **Overlap:** overlap_en = 1, same stream → `z` high on bits 4 and 6; `match_cnt` = 2; `z_q` pulses one cycle after each.
- **Valid gaps:** stream 1,0,1,0 with `x_valid` low for 3 cycles between every bit → single `z` on the 4th valid bit; `z` low in all gap cycles.
- **Pattern reload:**
  - Feed 1,0,1; then `pat_load` with `pat_in` = 4'b0110 and x = 0 → no `z`.
  - Then feed 0,1,1,0 → `z` on the last bit.
  - The old partial pattern 1,0,1 never completes a match.
- **Reset mid-operation:** feed 1,0,1, pulse `rst` for 1 cycle, feed 0 → `z` stays 0; `match_cnt` = 0.
- **Counter saturation and clear:**
  - CNT_W = 2, overlap_en = 1, pattern 1111, eight 1s → `match_cnt` saturates at 3.
  - `cnt_clr` asserted together with a match → `match_cnt` = 0 after that edge.
  - With the macro undefined, `match_cnt` stays 0 throughout.
